// File: rtl/vga_pixel_unpacker_if.sv
// Pixel-stream and show-ahead FIFO signals shared between the VGA timing side and the unpacker.
interface vga_pixel_unpacker_if;
   logic         frame_start;
   logic         pixel_req;
   logic         data_fifo_empty;
   logic [127:0] data_fifo_rd_data;
   logic         vga_rd_valid;
   logic [23:0]  pixel_data;
   logic         pixel_valid;

   modport master (
      input  frame_start, pixel_req, data_fifo_empty, data_fifo_rd_data,
      output vga_rd_valid, pixel_data, pixel_valid
   );

   modport slave (
      output frame_start, pixel_req, data_fifo_empty, data_fifo_rd_data,
      input  vga_rd_valid, pixel_data, pixel_valid
   );
endinterface

// File: rtl/vga_pixel_unpacker.sv
// Unpacks 128-bit FIFO words into four 24-bit RGB pixels on VGA request, with
// frame tracking, underflow substitution and sticky status flags.
module vga_pixel_unpacker #(
   parameter int          IMAGE_WIDTH     = 640,
   parameter int          IMAGE_HEIGHT    = 480,
   parameter logic [23:0] UNDERFLOW_COLOR = 24'hFF00FF
) (
   input  logic                 clk,
   input  logic                 reset,
   vga_pixel_unpacker_if.master bus,
   input  logic                 underflow_clr,
   output logic                 underflow,
   output logic [15:0]          underflow_count,
   output logic                 frame_err
);
   localparam int TOTAL = IMAGE_WIDTH * IMAGE_HEIGHT;
   localparam int CNT_W = $clog2(TOTAL + 1);
   localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);

   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

   state_t            state_q, state_d;
   logic [3:0][31:0]  buf_q, buf_d;
   logic              vld_q, vld_d;
   logic [1:0]        idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              pv_q, pv_d;
   logic [23:0]       pd_q, pd_d;
   logic              uf_q, uf_d;
   logic [15:0]       ufc_q, ufc_d;
   logic              ferr_q, ferr_d;
   logic              in_frame, consume, pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         buf_q   <= '0;
         vld_q   <= 1'b0;
         idx_q   <= 2'd0;
         cnt_q   <= '0;
         pv_q    <= 1'b0;
         pd_q    <= 24'h0;
         uf_q    <= 1'b0;
         ufc_q   <= 16'h0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         vld_q   <= vld_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         pv_q    <= pv_d;
         pd_q    <= pd_d;
         uf_q    <= uf_d;
         ufc_q   <= ufc_d;
         ferr_q  <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      vld_d   = vld_q;
      idx_d   = idx_q;
      pv_d    = bus.pixel_req;
      pd_d    = pd_q;
      uf_d    = uf_q;
      ufc_d   = ufc_q;
      ferr_d  = ferr_q;
      pop     = 1'b0;

      // A frame_start makes this cycle's request the first pixel of the new frame.
      in_frame = (state_q == ACTIVE) || bus.frame_start;
      consume  = bus.pixel_req && in_frame;

      cnt_d = bus.frame_start ? '0 : cnt_q;
      if (consume) cnt_d = cnt_d + CNT_W'(1);
      if (in_frame) state_d = (cnt_d == TOTAL_C) ? DONE : ACTIVE;
      if (bus.frame_start && state_q == ACTIVE) ferr_d = 1'b1;

      if (bus.pixel_req) pd_d = 24'h0;
      if (consume) begin
         if (vld_q) begin
            pd_d  = buf_q[idx_q][23:0];
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) vld_d = 1'b0;
         end else begin
            pd_d = UNDERFLOW_COLOR;
            uf_d = 1'b1;
            if (ufc_q != 16'hFFFF) ufc_d = ufc_q + 16'd1;
         end
      end
      if (underflow_clr) begin
         uf_d  = 1'b0;
         ufc_d = 16'h0;
      end

      // Refill as soon as the buffer is (or is about to be) empty; held off in reset.
      pop = !bus.data_fifo_empty && !vld_d && !reset;
      if (pop) begin
         buf_d = bus.data_fifo_rd_data;
         vld_d = 1'b1;
         idx_d = 2'd0;
      end
   end

   assign bus.vga_rd_valid = pop;
   assign bus.pixel_valid  = pv_q;
   assign bus.pixel_data   = pd_q;
   assign underflow        = uf_q;
   assign underflow_count  = ufc_q;
   assign frame_err        = ferr_q;
endmodule

// File: doc/vga_pixel_unpacker.md
VGA_PIXEL_UNPACKER -- requirements
Module: vga_pixel_unpacker

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 480, meaning active lines per frame.
REQ-003 SHALL have parameter UNDERFLOW_COLOR, default 24'hFF00FF, meaning the pixel emitted when no data is buffered.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port frame_start, input, 1 bit: single-cycle pulse marking the first pixel slot of a frame.
REQ-007 SHALL have port pixel_req, input, 1 bit: VGA timing requests one pixel this cycle.
REQ-008 SHALL have port data_fifo_empty, input, 1 bit: show-ahead FIFO has no word.
REQ-009 SHALL have port data_fifo_rd_data, input, 128 bits: FIFO head word, valid while data_fifo_empty is 0.
REQ-010 SHALL have port vga_rd_valid, output, 1 bit: FIFO pop strobe, one word per high cycle.
REQ-011 SHALL have port pixel_data, output, 24 bits: {R[23:16],G[15:8],B[7:0]}.
REQ-012 SHALL have port pixel_valid, output, 1 bit: pixel_data is valid this cycle.
REQ-013 SHALL have port underflow_clr, input, 1 bit: clears underflow status.
REQ-014 SHALL have port underflow, output, 1 bit: sticky underflow flag.
REQ-015 SHALL have port underflow_count, output, 16 bits: saturating count of underflow pixels.
REQ-016 SHALL have port frame_err, output, 1 bit: sticky flag for frame_start received mid-frame.

Function
REQ-017 SHALL hold one 128-bit word buffer with a valid bit and a 2-bit pixel index; pixel k (0..3) is buffer bits [32k+23:32k]; bits [32k+31:32k+24] are ignored.
REQ-018 SHALL pop the FIFO (vga_rd_valid=1, buffer loaded from data_fifo_rd_data, index reset to 0) whenever data_fifo_empty=0 and the buffer is invalid or is consuming index 3 this cycle.
REQ-019 SHALL never assert vga_rd_valid while data_fifo_empty=1.
REQ-020 SHALL implement states IDLE, ACTIVE and DONE.
REQ-021 SHALL transition IDLE->ACTIVE on frame_start, clearing the frame pixel counter.
REQ-022 SHALL transition ACTIVE->DONE when the pixel counter reaches IMAGE_WIDTH*IMAGE_HEIGHT.
REQ-023 SHALL transition DONE->ACTIVE on frame_start.
REQ-024 SHALL, in ACTIVE, treat frame_start as a restart: set frame_err, clear the pixel counter, and retain buffer contents and index.
REQ-025 SHALL register pixel_valid and pixel_data one cycle after every pixel_req, in every state (latency exactly 1).
REQ-026 SHALL, in ACTIVE on pixel_req with the buffer valid, output pixel[index], advance the index (wrapping 3->0 and invalidating the buffer unless reloaded per REQ-018), and increment the pixel counter.
REQ-027 SHALL, in ACTIVE on pixel_req with the buffer invalid, output UNDERFLOW_COLOR, increment the pixel counter, set underflow, and increment underflow_count, saturating at 16'hFFFF.
REQ-028 SHALL, in IDLE or DONE on pixel_req, output 24'h000000 and consume nothing; prefetch per REQ-018 continues.
REQ-029 SHALL, on a frame_start and pixel_req in the same cycle, treat the request as the first pixel of the new frame.
REQ-030 SHALL give underflow_clr priority over a same-cycle underflow event when clearing underflow and underflow_count.
REQ-031 SHALL size the pixel counter as $clog2(IMAGE_WIDTH*IMAGE_HEIGHT+1) bits.

Reset
REQ-032 SHALL, on reset, set state=IDLE, buffer invalid, index=0, pixel counter=0, vga_rd_valid=0, pixel_valid=0, pixel_data=0, underflow=0, underflow_count=0 and frame_err=0.
REQ-033 SHALL, on reset mid-frame, discard the buffered word without popping the FIFO; FIFO flushing is upstream's responsibility.

Verification
REQ-034 SHALL pass this scenario: 10x10 parameters, FIFO preloaded with 25 words of incrementing pixels, frame_start, then 100 pixel_req -> 100 pixels 0..99 in order, 25 pops, state DONE, underflow=0.
REQ-035 SHALL pass this scenario: continuous pixel_req across a word boundary with FIFO non-empty -> pop on the cycle index 3 is consumed, with no pixel gap.
REQ-036 SHALL pass this scenario: FIFO empty, frame_start, then 3 pixel_req -> 3 x 24'hFF00FF, underflow=1, underflow_count=3; then underflow_clr -> both 0.
REQ-037 SHALL pass this scenario: frame_start at pixel 40 of an ACTIVE frame -> frame_err=1, counter restarts, and DONE is reached after 100 further pixels.
REQ-038 SHALL pass this scenario: pixel_req in IDLE with data present -> 24'h000000, exactly one prefetch pop, and no further pops.
REQ-039 SHALL pass this scenario: reset asserted mid-frame -> all outputs take the REQ-032 values on the next cycle.
